// File: rtl/rpn_host_uart_tx.sv
// Host-side 8N1 UART transmitter with an input byte FIFO; drives the calculator's i_rx.
// Optional macro HOST_TX_GAP_EN adds GAP_BITS idle bit-times after every stop bit.
module rpn_host_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int GAP_BITS     = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef HOST_TX_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             push, pop;
  logic [7:0]       mem_q [FIFO_DEPTH];

`ifdef HOST_TX_GAP_EN
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  // GAP_BITS is only consumed by the gap build; this keeps it referenced otherwise.
  if (GAP_BITS < 0) begin : g_gap_bits_unused
  end
`endif

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
`ifdef HOST_TX_GAP_EN
    gap_d    = gap_q;
`endif
    push     = i_wr && !full_q;
    pop      = 1'b0;
    tx_d     = 1'b1;
    busy_d   = (state_q != S_IDLE);
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          done_d = 1'b1;
`ifdef HOST_TX_GAP_EN
          gap_d   = '0;
          state_d = S_GAP;
`else
          state_d = S_IDLE;
`endif
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef HOST_TX_GAP_EN
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else                                  gap_d   = gap_q + 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A write while full is dropped even if a pop frees a slot this cycle.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (PTR_W+1)'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef HOST_TX_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef HOST_TX_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  // NOTE: storage has no reset; the count and pointers alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_rpn_host_uart_tx.sv
// Randomized bench for rpn_host_uart_tx against a frame-timeline reference model.
module tb_rpn_host_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int GBITS = 2;
  localparam int FRAME = 10 * CPB;
`ifdef HOST_TX_GAP_EN
  localparam int GAP = GBITS * CPB;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wdata;
  logic       full, empty, tx, busy, done;

  rpn_host_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .GAP_BITS    (GBITS)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wr     (wr),
    .i_wr_data(wdata),
    .o_full   (full),
    .o_empty  (empty),
    .o_tx     (tx),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the start edge of the frame in flight.
  // A pop happens on an edge where the transmitter is idle and the queue was non-empty;
  // the line follows start/data/stop as a pure function of cycles since that pop.
  logic [7:0] mq[$];
  int         cyc     = 0;
  int         next_ok = 0;
  bit         act     = 1'b0;
  int         cur_t   = 0;
  logic [7:0] cur_b   = '0;
  int         sent    = 0;

  task automatic step();
    int d, k, cnt;
    bit pu, po;
    logic etx, ebusy, edone;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      act     = 1'b0;
      next_ok = cyc + 1;
    end else begin
      cnt = mq.size();
      po  = (cyc >= next_ok) && (cnt > 0);
      pu  = wr && (cnt < DEPTH);
      if (po) begin
        cur_b   = mq.pop_front();
        cur_t   = cyc;
        act     = 1'b1;
        next_ok = cyc + FRAME + GAP + 1;
        sent++;
      end
      if (pu) mq.push_back(wdata);
    end
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    if (act) begin
      d = cyc - cur_t;
      if (d >= 1 && d <= FRAME) begin
        ebusy = 1'b1;
        k = (d - 1) / CPB;
        if (k == 0)      etx = 1'b0;
        else if (k <= 8) etx = cur_b[k-1];
        edone = (d == FRAME);
      end else if (d > FRAME && d <= FRAME + GAP) begin
        ebusy = 1'b1;
      end
    end
    #1;
    check("tx",    32'(tx),    32'(etx));
    check("busy",  32'(busy),  32'(ebusy));
    check("done",  32'(done),  32'(edone));
    check("full",  32'(full),  32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
  endtask

  task automatic put(input logic [7:0] b);
    wr = 1'b1; wdata = b;
    step();
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || cyc < next_ok) && n < 3000) begin
      step();
      n++;
    end
    check("drain_bound", 32'(n < 3000), 32'd1);
    idle(2);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wdata = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single byte 0x33.
    put(8'h33);
    idle(45);

    // Expression burst "12+=".
    put(8'h31); put(8'h32); put(8'h2B); put(8'h3D);
    drain();

    // Overflow: 18 back-to-back writes, the last one finds the FIFO full.
    for (int i = 0; i < 18; i++) put(8'(i));
    check("ovf_full", 32'(full), 32'd1);
    drain();

    // Reset during data bit 3 with a second byte still buffered.
    put(8'h55); put(8'hA5);
    idle(4 * CPB + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_tx",    32'(tx),    32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    idle(60);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      wr    = ($urandom_range(0, 9) < 3);
      wdata = 8'($urandom);
      rst   = ($urandom_range(0, 599) == 0);
      step();
    end
    wr = 1'b0; rst = 1'b0;
    drain();
    check("frames_sent", 32'(sent > 20), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
